// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the LED blink generator: mode encoding and
// the half-period length derived from the clock and blink frequencies.
package led_blink_pkg;

    typedef enum logic {
        MODE_BLINK = 1'b0,
        MODE_CHASE = 1'b1
    } mode_e;

    // Clock cycles per half blink period; a non-positive blink rate yields 0,
    // which the top-level elaboration check rejects.
    function automatic int calc_half(input int clk_hz, input int blink_hz);
        if (blink_hz < 1) begin
            return 0;
        end
        return clk_hz / (2 * blink_hz);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser for an asynchronous switch bus, followed by a
// per-bit debouncer when LED_BLINK_DEBOUNCE_EN is defined.
module sw_debounce #(
    parameter int WIDTH      = 1,
    parameter int DEB_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("sw_debounce: WIDTH must be at least 1");
        end
        if (DEB_CYCLES < 1) begin : g_bad_deb
            $error("sw_debounce: DEB_CYCLES must be at least 1");
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

`ifdef LED_BLINK_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    // Each bit counts consecutive cycles of disagreement with its stable
    // value; the stable value follows only after DEB_CYCLES such samples.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_deb
            logic [CNT_W-1:0] r_cnt;
            logic             r_stable;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (r_sync[gi] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    r_cnt    <= '0;
                    r_stable <= r_sync[gi];
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign o_sync[gi] = r_stable;
        end
    endgenerate
`else
    assign o_sync = r_sync;
`endif

endmodule

// File: rtl/led_blink_gen.sv
// Multi-channel LED blinker: all-in-phase blink or one-hot chaser, masked by
// per-channel enables. Define LED_BLINK_DEBOUNCE_EN to debounce the switches.
module led_blink_gen
    import led_blink_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BLINK_HZ    = 1,
    parameter int DEB_CYCLES  = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] sw_en,
    input  logic            sw_mode,
    output logic [N_CH-1:0] led,
    output logic            tick
);

    localparam int                HALF        = calc_half(CLK_FREQ_HZ, BLINK_HZ);
    localparam int                PRESC_W     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(HALF - 1);
    localparam logic [N_CH-1:0]   ONEHOT_INIT = N_CH'(1);

    generate
        if (HALF < 2) begin : g_bad_half
            $error("led_blink_gen: half period must be at least 2 cycles");
        end
        if ((N_CH < 1) || (N_CH > 16)) begin : g_bad_nch
            $error("led_blink_gen: N_CH must be within 1..16");
        end
    endgenerate

    logic [N_CH-1:0]    w_en_s;
    logic [0:0]         w_mode_s;
    mode_e              w_mode_req;
    logic               w_restart;
    logic               w_wrap;

    logic [PRESC_W-1:0] r_presc;
    logic               r_phase;
    logic [N_CH-1:0]    r_oh;
    logic               r_shown;
    mode_e              r_mode;
    logic               r_tick;
    logic [N_CH-1:0]    r_led;

    logic [PRESC_W-1:0] w_presc_next;
    logic               w_phase_next;
    logic [N_CH-1:0]    w_oh_rot;
    logic [N_CH-1:0]    w_oh_next;
    logic               w_shown_next;
    mode_e              w_mode_next;
    logic               w_tick_next;
    logic [N_CH-1:0]    w_pattern;
    logic [N_CH-1:0]    w_led_next;

    sw_debounce #(
        .WIDTH      (N_CH),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_en_sync (
        .CLK     (CLK),
        .RST     (RST),
        .i_async (sw_en),
        .o_sync  (w_en_s)
    );

    sw_debounce #(
        .WIDTH      (1),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_mode_sync (
        .CLK     (CLK),
        .RST     (RST),
        .i_async (sw_mode),
        .o_sync  (w_mode_s)
    );

    assign w_mode_req = mode_e'(w_mode_s);
    assign w_restart  = (w_mode_req != r_mode);
    assign w_wrap     = (r_presc == PRESC_LAST);

    generate
        if (N_CH == 1) begin : g_rot_one
            assign w_oh_rot = r_oh;
        end else begin : g_rot
            assign w_oh_rot = {r_oh[N_CH-2:0], r_oh[N_CH-1]};
        end
    endgenerate

    // A restart wins over a coincident wrap, so that wrap never produces a tick.
    always_comb begin
        w_presc_next = r_presc + PRESC_W'(1);
        w_phase_next = r_phase;
        w_oh_next    = r_oh;
        w_shown_next = r_shown;
        w_mode_next  = r_mode;
        w_tick_next  = 1'b0;
        if (w_restart) begin
            w_presc_next = '0;
            w_phase_next = 1'b0;
            w_oh_next    = ONEHOT_INIT;
            w_shown_next = 1'b0;
            w_mode_next  = w_mode_req;
        end else if (w_wrap) begin
            w_presc_next = '0;
            w_phase_next = ~r_phase;
            w_oh_next    = w_oh_rot;
            w_shown_next = 1'b1;
            w_tick_next  = 1'b1;
        end
    end

    // LEDs stay dark from reset or restart until the first wrap shows a pattern.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_pattern
            assign w_pattern[gi]  = (w_mode_next == MODE_CHASE) ? w_oh_next[gi] : w_phase_next;
            assign w_led_next[gi] = w_shown_next & w_pattern[gi] & w_en_s[gi];
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_presc <= '0;
            r_phase <= 1'b0;
            r_oh    <= ONEHOT_INIT;
            r_shown <= 1'b0;
            r_mode  <= MODE_BLINK;
            r_tick  <= 1'b0;
            r_led   <= '0;
        end else begin
            r_presc <= w_presc_next;
            r_phase <= w_phase_next;
            r_oh    <= w_oh_next;
            r_shown <= w_shown_next;
            r_mode  <= w_mode_next;
            r_tick  <= w_tick_next;
            r_led   <= w_led_next;
        end
    end

    assign led  = r_led;
    assign tick = r_tick;

endmodule

// File: doc/led_blink_gen.md
LED_BLINK_GEN -- requirements
Module: led_blink_gen

Interface
REQ-001 Parameter: N_CH, default 4, number of LED channels (1..16).
REQ-002 Parameter: CLK_FREQ_HZ, default 50000000, CLK frequency.
REQ-003 Parameter: BLINK_HZ, default 1, full blink rate; HALF = CLK_FREQ_HZ/(2*BLINK_HZ).
REQ-004 Parameter: DEB_CYCLES, default 16, debounce stability window in CLK cycles.
REQ-005 Port: CLK  in  1  single clock, all logic rising-edge.
REQ-006 Port: RST  in  1  reset, asynchronous, active-high.
REQ-007 Port: sw_en  in  N_CH  per-channel enable switches, asynchronous to CLK.
REQ-008 Port: sw_mode  in  1  asynchronous mode switch: 0 = blink all in phase, 1 = chaser.
REQ-009 Port: led  out  N_CH  registered LED drive, 1 = lit.
REQ-010 Port: tick  out  1  registered one-cycle pulse at each half-period boundary.

Function
REQ-011 sw_en and sw_mode SHALL each pass a 2-flop synchroniser; synchronised value valid 2 cycles after input edge.
REQ-012 Prescaler SHALL count 0..HALF-1, width $clog2(HALF), wrap to 0 after HALF-1.
REQ-013 tick SHALL be 1 for exactly the cycle after prescaler = HALF-1, else 0; period HALF cycles.
REQ-014 Phase bit SHALL toggle on each prescaler wrap.
REQ-015 One-hot register (N_CH bits) SHALL rotate left on each wrap, bit N_CH-1 wrapping to bit 0; N_CH=1 keeps bit 0 set.
REQ-016 Mode 0: led SHALL equal {N_CH{phase}} AND en_s (synchronised enables).
REQ-017 Mode 1: led SHALL equal one-hot AND en_s.
REQ-018 led SHALL be registered: changes 1 cycle after the wrap that updates phase/one-hot, same cycle as tick.
REQ-019 Synchronised mode change SHALL restart: prescaler to 0, phase to 0, one-hot to bit 0, next cycle; no tick that cycle.
REQ-020 Mode change coinciding with prescaler = HALF-1 SHALL take the restart; wrap is discarded.
REQ-021 Enable change SHALL affect only led masking, never prescaler, phase or one-hot.
REQ-022 HALF < 2 or N_CH outside 1..16 SHALL be an elaboration error.

Reset
REQ-023 RST asserted SHALL immediately force: led = 0, tick = 0, prescaler = 0, phase = 0, one-hot = bit 0, synchroniser and debounce state = 0.
REQ-024 After RST deasserts, first wrap SHALL occur HALF cycles later; RST mid-period discards the partial count.

Configuration
REQ-025 Macro LED_BLINK_DEBOUNCE_EN defined: each synchronised switch SHALL pass a debouncer; output updates only after DEB_CYCLES consecutive equal samples.
REQ-026 Macro undefined: debouncer absent; synchronised switches used directly (latency 2 cycles, glitches propagate).

Structure
REQ-027 Shared package led_blink_pkg SHALL hold the mode enum (MODE_BLINK=0, MODE_CHASE=1) and the HALF computation function.
REQ-028 Synchroniser plus debouncer SHALL be one sub-module sw_debounce (parameter DEB_CYCLES, width), instantiated per switch bus.

Verification (CLK_FREQ_HZ=20, BLINK_HZ=1 -> HALF=10, N_CH=4, DEB_CYCLES=4)
REQ-029 Reset, sw_en=4'hF, sw_mode=0 -> tick every 10 cycles; led alternates 4'hF / 4'h0 each tick, first 4'hF 10 cycles after reset release.
REQ-030 sw_mode=1, sw_en=4'hF -> led sequence 0010, 0100, 1000, 0001 at successive ticks after restart (initial register 0001, led 0 until first tick).
REQ-031 sw_mode toggled when prescaler = 9 -> no tick that period; next tick 10 cycles after restart; phase/one-hot restarted.
REQ-032 sw_en=4'b0101, mode 0 -> led toggles 0101 / 0000; tick timing unchanged.
REQ-033 RST pulsed mid-period (prescaler=5) -> led=0, tick=0 immediately without clock edge; next tick 10 cycles after release.
REQ-034 With LED_BLINK_DEBOUNCE_EN: 2-cycle glitch on sw_en[0] -> led[0] unchanged; 6-cycle stable change -> applied after 2+4 cycles.
